// File: rtl/lsu.sv
// Load/store unit: turns byte-addressed B/H/W requests into one or two
// word accesses on a dmem with per-byte write enables, synchronous write and
// asynchronous read. Misaligned accesses crossing a word boundary are split
// into two consecutive word accesses (second word address wraps).
//
// Handshake: a request is taken on a rising edge where req_valid && req_ready;
// req_ready is high only while idle, and req_* are ignored at all other times.
// The result appears as a single-cycle resp_valid pulse with resp_rdata and
// resp_err valid only in that cycle.
module lsu #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [AWIDTH+1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DWIDTH-1:0] resp_rdata,
  output logic              resp_err,
  output logic [3:0]        mem_wbe,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_dataw,
  input  logic [DWIDTH-1:0] mem_datar
);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

  state_t state, state_next;

  logic              we_q;
  logic [2:0]        funct3_q;
  logic [AWIDTH+1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic [DWIDTH-1:0] low_q;

  logic [1:0]          off;
  logic [2:0]          size;
  logic                split;
  logic [7:0]          lanes;
  logic [AWIDTH-1:0]   word_q;
  logic [2*DWIDTH-1:0] store_word;
  logic [DWIDTH-1:0]   load_lo, load_hi;
  logic [2*DWIDTH-1:0] load_shifted;
  logic [DWIDTH-1:0]   load_result;
  logic                illegal_req;

  assign off    = addr_q[1:0];
  assign word_q = addr_q[AWIDTH+1:2];
  assign split  = ({1'b0, off} + size) > 3'd4;
  // Byte lanes touched across the two-word window starting at the first word.
  assign lanes  = ((8'd1 << size) - 8'd1) << off;
  assign store_word = {{DWIDTH{1'b0}}, wdata_q} << {off, 3'b000};

  // Access size in bytes from the registered size code.
  always_comb begin
    size = 3'd4;
    case (funct3_q[1:0])
      2'b00:   size = 3'd1;
      2'b01:   size = 3'd2;
      default: size = 3'd4;
    endcase
  end

  // Illegal size codes, and unsigned variants used with a store.
  always_comb begin
    illegal_req = 1'b0;
    case (req_funct3)
      3'b011, 3'b110, 3'b111: illegal_req = 1'b1;
      3'b100, 3'b101:         illegal_req = req_we;
      default:                illegal_req = 1'b0;
    endcase
  end

  // Load result: low word is live in ACC1 (unsplit) or captured (split);
  // high word is live only in ACC2.
  always_comb begin
    load_lo      = (state == ACC1) ? mem_datar : low_q;
    load_hi      = (state == ACC2) ? mem_datar : '0;
    load_shifted = {load_hi, load_lo} >> {off, 3'b000};
    case (funct3_q)
      3'b000:  load_result = {{24{load_shifted[7]}}, load_shifted[7:0]};
      3'b001:  load_result = {{16{load_shifted[15]}}, load_shifted[15:0]};
      3'b100:  load_result = {24'd0, load_shifted[7:0]};
      3'b101:  load_result = {16'd0, load_shifted[15:0]};
      default: load_result = load_shifted[DWIDTH-1:0];
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = illegal_req ? RESP : ACC1;
      ACC1:    state_next = split ? ACC2 : RESP;
      ACC2:    state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory-side and handshake outputs; write enables are suppressed while rst
  // is high so an aborted ACC2 never reaches the memory.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    mem_addr   = word_q;
    mem_dataw  = store_word[DWIDTH-1:0];
    mem_wbe    = 4'b0000;
    case (state)
      ACC1: begin
        if (we_q && !rst) mem_wbe = lanes[3:0];
      end
      ACC2: begin
        mem_addr  = word_q + AWIDTH'(1);
        mem_dataw = store_word[2*DWIDTH-1:DWIDTH];
        if (we_q && !rst) mem_wbe = lanes[7:4];
      end
      default: ;
    endcase
  end

  // State register, request capture and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      low_q      <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            funct3_q   <= req_funct3;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            resp_err   <= illegal_req;
            resp_rdata <= '0;
          end
        end
        ACC1: begin
          low_q <= mem_datar;
          if (!split) resp_rdata <= we_q ? '0 : load_result;
        end
        ACC2:    resp_rdata <= we_q ? '0 : load_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed vector table, multi-cycle corner sequences
// (split access with wrap, reset abort) and random traffic against a
// byte-array reference of the memory.
module tb_lsu;
  localparam int AW = 14;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'b000;
  logic [AW+1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [3:0]    mem_wbe;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_dataw;
  logic [31:0]   mem_datar;

  always #5 clk = ~clk;

  lsu #(.DWIDTH(32), .AWIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_wbe(mem_wbe), .mem_addr(mem_addr), .mem_dataw(mem_dataw),
    .mem_datar(mem_datar)
  );

  // dmem: per-byte write enables, synchronous write, asynchronous read.
  logic [31:0] dmem [0:(1<<AW)-1] = '{default: '0};
  assign mem_datar = dmem[mem_addr];
  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (mem_wbe[i]) dmem[mem_addr][8*i +: 8] <= mem_dataw[8*i +: 8];

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model (byte memory) ----------------
  logic [7:0] ref_mem [0:(1<<(AW+2))-1];

  function automatic int f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (f3[2] && we);
  endfunction

  function automatic logic [31:0] ref_load(input logic [15:0] a, input logic [2:0] f3);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < f3_size(f3); i++) v[8*i +: 8] = ref_mem[a + 16'(i)];
    if (f3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
    if (f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic ref_store(input logic [15:0] a, input logic [2:0] f3, input logic [31:0] wd);
    for (int i = 0; i < f3_size(f3); i++) ref_mem[a + 16'(i)] = wd[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_word(input logic [AW-1:0] w);
    return {ref_mem[{w, 2'd3}], ref_mem[{w, 2'd2}], ref_mem[{w, 2'd1}], ref_mem[{w, 2'd0}]};
  endfunction

  // ---------------- driver ----------------
  logic [31:0]   r_rdata;
  logic          r_err;
  int            r_lat;
  logic [3:0]    r_wbe [0:1];
  logic [AW-1:0] r_ma  [0:1];
  logic          r_wbe_any;

  // Issue one request from IDLE; garbage with req_valid=1 is driven while busy
  // and must be ignored. Returns with the DUT back in IDLE.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [15:0] a, input logic [31:0] wd);
    int k;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_we     = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr   = 16'($urandom_range(0, 65535));
    req_wdata  = $urandom;
    r_wbe[0] = '0; r_wbe[1] = '0; r_ma[0] = '0; r_ma[1] = '0;
    r_wbe_any = 1'b0; k = 0; r_lat = 1;
    while (!resp_valid && r_lat < 8) begin
      if (k == 0) check("req_ready_busy", 32'(req_ready), 32'd0);
      if (k < 2) begin r_wbe[k] = mem_wbe; r_ma[k] = mem_addr; end
      r_wbe_any |= (mem_wbe != 4'b0000);
      k++;
      @(posedge clk); #1;
      r_lat++;
    end
    check("resp_valid", 32'(resp_valid), 32'd1);
    r_wbe_any |= (mem_wbe != 4'b0000);
    r_rdata = resp_rdata;
    r_err   = resp_err;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("resp_one_pulse", 32'(resp_valid), 32'd0);
  endtask

  // Request checked entirely against the reference model.
  task automatic run_ref(input logic we, input logic [2:0] f3, input logic [15:0] a, input logic [31:0] wd);
    logic          ill;
    logic [31:0]   exp_rd;
    int            exp_lat;
    logic [AW-1:0] w;
    ill     = f3_illegal(we, f3);
    exp_rd  = (ill || we) ? 32'd0 : ref_load(a, f3);
    exp_lat = ill ? 1 : ((int'(a[1:0]) + f3_size(f3) > 4) ? 3 : 2);
    w       = a[15:2];
    do_req(we, f3, a, wd);
    check("rnd_rdata", r_rdata, exp_rd);
    check("rnd_err", 32'(r_err), 32'(ill));
    check("rnd_latency", r_lat, exp_lat);
    if (!ill) check("rnd_mem_addr", 32'(r_ma[0]), 32'(w));
    if (ill || !we) check("rnd_no_write", 32'(r_wbe_any), 32'd0);
    if (!ill && we) begin
      ref_store(a, f3, wd);
      check("rnd_mem_w0", dmem[w], ref_word(w));
      check("rnd_mem_w1", dmem[w + AW'(1)], ref_word(w + AW'(1)));
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    logic [3:0]  exp_wbe0;
    logic [3:0]  exp_wbe1;
    logic [13:0] exp_ma0;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  initial begin
    for (int i = 0; i < (1 << (AW + 2)); i++) ref_mem[i] = 8'h00;

    //            we    f3      addr      wdata          exp_rd        err  lat wbe0     wbe1     ma0
    vecs[0]  = '{1'b1, 3'b010, 16'h0000, 32'hdeadbeef, 32'h00000000, 1'b0, 2, 4'b1111, 4'b0000, 14'h0};
    vecs[1]  = '{1'b0, 3'b000, 16'h0003, 32'h0,        32'hffffffde, 1'b0, 2, 4'b0000, 4'b0000, 14'h0};
    vecs[2]  = '{1'b0, 3'b100, 16'h0003, 32'h0,        32'h000000de, 1'b0, 2, 4'b0000, 4'b0000, 14'h0};
    vecs[3]  = '{1'b0, 3'b001, 16'h0002, 32'h0,        32'hffffdead, 1'b0, 2, 4'b0000, 4'b0000, 14'h0};
    vecs[4]  = '{1'b1, 3'b001, 16'h0007, 32'h0000cafe, 32'h00000000, 1'b0, 3, 4'b1000, 4'b0001, 14'h1};
    vecs[5]  = '{1'b0, 3'b010, 16'h0000, 32'h0,        32'hdeadbeef, 1'b0, 2, 4'b0000, 4'b0000, 14'h0};
    vecs[6]  = '{1'b0, 3'b101, 16'h0007, 32'h0,        32'h0000cafe, 1'b0, 3, 4'b0000, 4'b0000, 14'h1};
    vecs[7]  = '{1'b0, 3'b011, 16'h0000, 32'h0,        32'h00000000, 1'b1, 1, 4'b0000, 4'b0000, 14'h0};
    vecs[8]  = '{1'b1, 3'b100, 16'h0004, 32'hffffffff, 32'h00000000, 1'b1, 1, 4'b0000, 4'b0000, 14'h0};
    vecs[9]  = '{1'b1, 3'b101, 16'h0008, 32'hffffffff, 32'h00000000, 1'b1, 1, 4'b0000, 4'b0000, 14'h0};
    vecs[10] = '{1'b0, 3'b110, 16'h000c, 32'h0,        32'h00000000, 1'b1, 1, 4'b0000, 4'b0000, 14'h0};
    vecs[11] = '{1'b1, 3'b111, 16'h0000, 32'hffffffff, 32'h00000000, 1'b1, 1, 4'b0000, 4'b0000, 14'h0};
    vecs[12] = '{1'b0, 3'b000, 16'h0007, 32'h0,        32'hfffffffe, 1'b0, 2, 4'b0000, 4'b0000, 14'h1};
    vecs[13] = '{1'b0, 3'b001, 16'h0001, 32'h0,        32'hffffadbe, 1'b0, 2, 4'b0000, 4'b0000, 14'h0};

    // ---------- reset state ----------
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_mem_wbe", 32'(mem_wbe), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);

    // ---------- table ----------
    for (int i = 0; i < NV; i++) begin
      do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d_rdata", i), r_rdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_err", i), 32'(r_err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_latency", i), r_lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_wbe0", i), 32'(r_wbe[0]), 32'(vecs[i].exp_wbe0));
      check($sformatf("vec%0d_wbe1", i), 32'(r_wbe[1]), 32'(vecs[i].exp_wbe1));
      if (vecs[i].exp_lat > 1) check($sformatf("vec%0d_mem_addr", i), 32'(r_ma[0]), 32'(vecs[i].exp_ma0));
      else check($sformatf("vec%0d_no_write", i), 32'(r_wbe_any), 32'd0);
      if (vecs[i].we && !vecs[i].exp_err) ref_store(vecs[i].addr, vecs[i].f3, vecs[i].wdata);
    end
    check("sw_mem0", dmem[0], 32'hdeadbeef);
    check("sh_split_w1_byte3", 32'(dmem[1][31:24]), 32'hfe);
    check("sh_split_w2_byte0", 32'(dmem[2][7:0]), 32'hca);
    check("illegal_store_w1", dmem[1], 32'hfe000000);

    // ---------- split LW across words 1/2 ----------
    run_ref(1'b1, 3'b010, 16'h0004, 32'h11223344);
    run_ref(1'b1, 3'b010, 16'h0008, 32'h55667788);
    do_req(1'b0, 3'b010, 16'h0006, 32'h0);
    check("lw_split_rdata", r_rdata, 32'h77881122);
    check("lw_split_latency", r_lat, 3);
    check("lw_split_addr0", 32'(r_ma[0]), 32'd1);
    check("lw_split_addr1", 32'(r_ma[1]), 32'd2);

    // ---------- reset during ACC2 of a wrapping SW ----------
    run_ref(1'b1, 3'b010, 16'h0000, 32'h12345678);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 16'hfffe; req_wdata = 32'haabbccdd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_acc1_wbe", 32'(mem_wbe), 32'b1100);
    check("abort_acc1_addr", 32'(mem_addr), 32'h3fff);
    @(posedge clk); #1;
    check("abort_acc2_addr_wrap", 32'(mem_addr), 32'd0);
    // Reset held two edges with a competing store request present.
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 16'h0000; req_wdata = 32'hffffffff;
    #1;
    check("abort_acc2_wbe_gated", 32'(mem_wbe), 32'd0);
    @(posedge clk); #1;
    check("abort_no_resp", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    #1;
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_addr_cleared", 32'(mem_addr), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort_quiet_resp", 32'(resp_valid), 32'd0);
      check("abort_quiet_ready", 32'(req_ready), 32'd1);
    end
    check("abort_w3fff", dmem[14'h3fff], 32'hccdd0000);
    check("abort_w0_unchanged", dmem[0], 32'h12345678);
    ref_mem[16'hfffe] = 8'hdd;
    ref_mem[16'hffff] = 8'hcc;
    do_req(1'b0, 3'b001, 16'hffff, 32'h0);
    check("lh_wrap_rdata", r_rdata, 32'h000078cc);
    check("lh_wrap_latency", r_lat, 3);
    check("lh_wrap_addr0", 32'(r_ma[0]), 32'h3fff);
    check("lh_wrap_addr1", 32'(r_ma[1]), 32'd0);

    // ---------- random traffic ----------
    for (int i = 0; i < 300; i++) begin
      logic [15:0] a;
      if ($urandom_range(0, 3) == 0) a = 16'hffc0 + 16'($urandom_range(0, 63));
      else a = 16'($urandom_range(0, 127));
      run_ref(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
